// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA timing generator:
//   - 640x480@60 default geometry (25 MHz pixel clock)
//   - derived line/frame totals and the counter width they must fit in
//   - FSM state encoding and the 24-bit pixel colour type
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Counters and pipeline arithmetic are unsigned, 10 bits wide.
  localparam int unsigned CNT_W         = 10;
  localparam int unsigned CNT_MAX_TOTAL = 1 << CNT_W;

  // 640x480@60 defaults.
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Total period of one axis: visible + front porch + sync + back porch.
  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned DEF_H_TOTAL =
    axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);   // 800
  localparam int unsigned DEF_V_TOTAL =
    axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);   // 525

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_e;

  // {R,G,B}, R in the most significant byte.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

endpackage

// File: rtl/vga_timing_counter.sv
// -----------------------------------------------------------------------------
// vga_timing_counter
// Run/idle FSM plus the horizontal and vertical raster counters.
//   clk       in   pixel clock
//   rst_n     in   asynchronous active-low reset
//   lock_s_i  in   synchronised PLL lock
//   run_o     out  1 while the FSM is in RUN
//   h_cnt_o   out  column counter, 0..H_TOTAL-1 (held at 0 in IDLE)
//   v_cnt_o   out  row counter,    0..V_TOTAL-1 (held at 0 in IDLE)
// -----------------------------------------------------------------------------
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL = DEF_H_TOTAL,
  parameter int unsigned V_TOTAL = DEF_V_TOTAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lock_s_i,
  output logic             run_o,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  fsm_state_e       state_q;
  logic [CNT_W-1:0] h_cnt_q;
  logic [CNT_W-1:0] v_cnt_q;
  logic [CNT_W-1:0] h_cnt_d;
  logic [CNT_W-1:0] v_cnt_d;

  // Raster advance with wrap; the row only moves when the column wraps.
  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Counters parked at the origin so the first RUN cycle is h=0, v=0.
          h_cnt_q <= '0;
          v_cnt_q <= '0;
          if (lock_s_i) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!lock_s_i) begin
            // Lock loss aborts the frame wherever it is.
            state_q <= ST_IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
          end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          h_cnt_q <= '0;
          v_cnt_q <= '0;
        end
      endcase
    end
  end

  assign run_o   = (state_q == ST_RUN);
  assign h_cnt_o = h_cnt_q;
  assign v_cnt_o = v_cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator with a pixel-request interface.
//   clk          in   25 MHz pixel clock
//   rst_n        in   asynchronous active-low reset
//   pll_locked   in   PLL lock, asynchronous to clk (synchronised here)
//   pix_req      out  request pixel (pix_x, pix_y) this cycle
//   pix_x/pix_y  out  requested coordinate, 0 when not requesting
//   pix_rgb      in   {R,G,B}, valid exactly one cycle after pix_req
//   sof          out  one-cycle pulse on the first pixel of each frame
//   vga_r/g/b    out  DAC colour, 0 outside the active region
//   vga_hs/vs    out  active-low syncs
//   vga_blank_n  out  low outside the active region
//   vga_sync_n   out  constant 0
// Counter state reaches the pins through two register stages; the colour
// returned for a request lands in the second stage alongside its timing.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  output logic             pix_req,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  input  logic [23:0]      pix_rgb,
  output logic             sof,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_blank_n,
  output logic             vga_sync_n
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > CNT_MAX_TOTAL || V_TOTAL > CNT_MAX_TOTAL) begin : g_bad_geometry
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // --- lock synchroniser ----------------------------------------------------
  logic [1:0] lock_sync_q;
  logic       lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_sync_q <= 2'b00;
    else        lock_sync_q <= {lock_sync_q[0], pll_locked};
  end

  assign lock_s = lock_sync_q[1];

  // --- raster counters + FSM ------------------------------------------------
  logic             run;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  vga_timing_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .lock_s_i (lock_s),
    .run_o    (run),
    .h_cnt_o  (h_cnt),
    .v_cnt_o  (v_cnt)
  );

  // --- stage 0: combinational decode ----------------------------------------
  logic active_d;
  logic hs_n_d;
  logic vs_n_d;

  always_comb begin
    // Gate with run: the parked IDLE counters sit at (0,0), which is visible.
    active_d = run && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hs_n_d   = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    vs_n_d   = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
  end

  assign pix_req = active_d;
  assign pix_x   = active_d ? h_cnt : '0;
  assign pix_y   = active_d ? v_cnt : '0;
  assign sof     = run && (h_cnt == '0) && (v_cnt == '0);

  // --- stage 1: registered timing -------------------------------------------
  logic active_q;
  logic hs_n_q;
  logic vs_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      hs_n_q   <= 1'b1;
      vs_n_q   <= 1'b1;
    end else begin
      active_q <= active_d;
      hs_n_q   <= hs_n_d;
      vs_n_q   <= vs_n_d;
    end
  end

  // --- stage 2: pins --------------------------------------------------------
  // pix_rgb is the answer to the request that produced active_q, so it is
  // only trusted while active_q is set.
  logic [23:0] rgb_d;

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign rgb_d[gi*8 +: 8] = active_q ? pix_rgb[gi*8 +: 8] : 8'h00;
  end

  rgb24_t rgb_q;
  logic   blank_n_q;
  logic   hs_q;
  logic   vs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q     <= '0;
      blank_n_q <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      rgb_q     <= rgb24_t'(rgb_d);
      blank_n_q <= active_q;
      hs_q      <= hs_n_q;
      vs_q      <= vs_n_q;
    end
  end

  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Reduced geometry keeps whole frames short; all expectations scale with it.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 25
  localparam int VT = VA + VF + VS + VB;   // 13
  localparam int FT = HT * VT;             // 325

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pll_locked;
  logic        pix_req;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [23:0] pix_rgb;
  logic        sof;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n;

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .pix_req     (pix_req),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_rgb     (pix_rgb),
    .sof         (sof),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .vga_sync_n  (vga_sync_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: lock history, frame position t (cycles since RUN
  // began, modulo the frame), and the two-cycle delay to the pins.
  bit        m_s1, m_s2;
  bit        m_run;
  int        m_t;
  bit        m_a1, m_h1, m_v1;
  bit        e_hs, e_vs, e_blank;
  bit [23:0] e_rgb;
  bit        m_prev_req;
  int        m_prev_x, m_prev_y;
  bit        rgb_rand;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_sync_h(input int h);
    return (h >= HA + HF) && (h < HA + HF + HS);
  endfunction

  function automatic bit in_sync_v(input int v);
    return (v >= VA + VF) && (v < VA + VF + VS);
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_run = 0; m_t = 0;
    m_a1 = 0; m_h1 = 1; m_v1 = 1;
    e_hs = 1; e_vs = 1; e_blank = 0; e_rgb = '0;
    m_prev_req = 0; m_prev_x = 0; m_prev_y = 0;
  endtask

  // One rising edge of the reference, using inputs present at that edge.
  task automatic model_edge();
    bit [23:0] p;
    bit        l;
    int        h, v;
    p = pix_rgb;
    l = pll_locked;
    h = m_t % HT;
    v = m_t / HT;
    e_hs    = m_h1;
    e_vs    = m_v1;
    e_blank = m_a1;
    e_rgb   = m_a1 ? p : 24'h0;
    m_a1 = m_run && (h < HA) && (v < VA);
    m_h1 = !in_sync_h(h);
    m_v1 = !in_sync_v(v);
    if (m_run) begin
      if (m_s2) m_t = (m_t + 1) % FT;
      else begin m_run = 0; m_t = 0; end
    end else if (m_s2) begin
      m_run = 1; m_t = 0;
    end
    m_s2 = m_s1;
    m_s1 = l;
  endtask

  task automatic check_outputs();
    int h, v;
    bit req;
    h   = m_t % HT;
    v   = m_t / HT;
    req = m_run && (h < HA) && (v < VA);
    chk("pix_req",     32'(pix_req),     32'(req));
    chk("pix_x",       32'(pix_x),       req ? h : 0);
    chk("pix_y",       32'(pix_y),       req ? v : 0);
    chk("sof",         32'(sof),         32'(m_run && m_t == 0));
    chk("vga_hs",      32'(vga_hs),      32'(e_hs));
    chk("vga_vs",      32'(vga_vs),      32'(e_vs));
    chk("vga_blank_n", 32'(vga_blank_n), 32'(e_blank));
    chk("vga_rgb",     {8'h00, vga_r, vga_g, vga_b}, {8'h00, e_rgb});
    chk("vga_sync_n",  32'(vga_sync_n),  0);
  endtask

  // Answer the request of the previous cycle, garbage when there was none.
  task automatic drive_rgb();
    int h, v;
    if (!rgb_rand && m_prev_req)
      pix_rgb = {m_prev_x[7:0], m_prev_y[7:0], 8'hA5};
    else
      pix_rgb = 24'($urandom);
    h = m_t % HT;
    v = m_t / HT;
    m_prev_req = m_run && (h < HA) && (v < VA);
    m_prev_x   = h;
    m_prev_y   = v;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    drive_rgb();
  endtask

  initial begin
    int n, first_blank, period, hs_first, hs_low, vs_low, blank_hi, rgb_leak;
    int drop_left;
    logic [23:0] px53;

    // --- reset with lock already high -----------------------------------
    rst_n = 1'b0; pll_locked = 1'b1; pix_rgb = 24'($urandom); rgb_rand = 0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n = 1'b1;

    // --- sof latency from reset release ---------------------------------
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (sof === 1'b1) begin n = i; break; end
    end
    chk("sof_latency_edges", n, 3);

    // --- one full frame, pattern pixels ---------------------------------
    first_blank = 0; period = 0; hs_first = 0; hs_low = 0; vs_low = 0;
    blank_hi = 0; rgb_leak = 0; px53 = '0;
    for (int i = 1; i <= FT; i++) begin
      step();
      if (sof === 1'b1 && period == 0) period = i;
      if (vga_blank_n === 1'b1) begin
        blank_hi++;
        if (first_blank == 0) first_blank = i;
      end else if ({vga_r, vga_g, vga_b} !== 24'h0) rgb_leak++;
      if (vga_hs === 1'b0) begin
        hs_low++;
        if (hs_first == 0) hs_first = i;
      end
      if (vga_vs === 1'b0) vs_low++;
      if (i == 3 * HT + 5 + 2) px53 = {vga_r, vga_g, vga_b};
    end
    chk("blank_after_sof",   first_blank, 2);
    chk("sof_period",        period, FT);
    chk("hs_first_low",      hs_first, HA + HF + 2);
    chk("hs_low_cycles",     hs_low, HS * VT);
    chk("vs_low_cycles",     vs_low, VS * HT);
    chk("blank_high_cycles", blank_hi, HA * VA);
    chk("rgb_outside_active", rgb_leak, 0);
    chk("pixel_5_3_rgb",     32'(px53), 32'h0005_03A5);

    // --- lock drop at h=10, v=5 -----------------------------------------
    n = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      if (m_run && m_t == 5 * HT + 10) begin n = 1; break; end
      step();
    end
    chk("reach_drop_point", n, 1);
    pll_locked = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (pix_req === 1'b0) begin n = i; break; end
    end
    chk("drop_req_edges", n, 3);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (vga_blank_n === 1'b0 && vga_hs === 1'b1 && vga_vs === 1'b1 &&
          {vga_r, vga_g, vga_b} === 24'h0) begin n = i; break; end
    end
    chk("drop_flush_edges", n, 2);
    repeat (5) step();

    // --- relock: frame restarts at the origin ---------------------------
    pll_locked = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (sof === 1'b1) begin n = i; break; end
    end
    chk("relock_sof_edges", n, 3);
    chk("relock_origin", {22'h0, pix_x}, 0);

    // --- random colours with random lock glitches -----------------------
    rgb_rand = 1; drop_left = 0;
    for (int i = 0; i < 3 * FT; i++) begin
      if (pll_locked && $urandom_range(0, 299) == 0) begin
        pll_locked = 1'b0;
        drop_left  = int'($urandom_range(1, 6));
      end else if (!pll_locked) begin
        drop_left--;
        if (drop_left <= 0) pll_locked = 1'b1;
      end
      step();
    end
    pll_locked = 1'b1;
    rgb_rand = 0;

    // --- asynchronous reset mid-line ------------------------------------
    n = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      step();
      if (m_run && (m_t % HT) == 7 && (m_t / HT) == 2) begin n = 1; break; end
    end
    chk("reach_async_point", n, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  H_ACTIVE  640  visible pixels per line
  H_FP  16  horizontal front porch (pixels)
  H_SYNC  96  horizontal sync width (pixels)
  H_BP  48  horizontal back porch (pixels)
  V_ACTIVE  480  visible lines
  V_FP  10  vertical front porch (lines)
  V_SYNC  2  vertical sync width (lines)
  V_BP  33  vertical back porch (lines)
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
  clk  in  1  25 MHz pixel clock (outclk_0 of the VGA/audio PLL)
  rst_n  in  1  asynchronous active-low reset
  pll_locked  in  1  PLL lock indication, asynchronous to clk
  pix_req  out  1  pixel request for coordinate pix_x/pix_y
  pix_x  out  10  requested column, 0..H_ACTIVE-1
  pix_y  out  10  requested row, 0..V_ACTIVE-1
  pix_rgb  in  24  {R,G,B} 8 bits each, valid exactly 1 cycle after pix_req
  sof  out  1  one-cycle start-of-frame pulse
  vga_r / vga_g / vga_b  out  8 each  pixel colour to DAC
  vga_hs / vga_vs  out  1 each  syncs, active low
  vga_blank_n  out  1  low outside the active region
  vga_sync_n  out  1  tied 0
REQ-003 The clock SHALL be clk only, and reset SHALL be asynchronous active-low on rst_n.

Function
REQ-004 pll_locked SHALL pass through a 2-flop synchroniser; lock_s is the synchronised value.
REQ-005 FSM states: IDLE, RUN. IDLE->RUN when lock_s=1. RUN->IDLE when lock_s=0, taking effect on the next edge, mid-frame included.
REQ-006 In IDLE: h_cnt=0, v_cnt=0, pix_req=0, sof=0, and the output pipeline drives hs=1, vs=1, blank_n=0, rgb=0.
REQ-007 In RUN: h_cnt wraps 0..H_TOTAL-1 (800). v_cnt increments when h_cnt wraps and itself wraps 0..V_TOTAL-1 (525). The first RUN cycle is h=0, v=0.
REQ-008 Stage 0 is combinational from the counters:
  - active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE)
  - pix_req = active; pix_x = h_cnt and pix_y = v_cnt when active, else 0
  - sof = RUN and h=0 and v=0
REQ-009 Sync decode: hs_n = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751). vs_n = 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-010 Stage 1 SHALL register active, hs_n and vs_n. pix_rgb is sampled on the same edge that ends stage 1.
REQ-011 Stage 2 outputs: vga_r/g/b = pix_rgb if active_d1 else 0; vga_hs, vga_vs and vga_blank_n = delayed stage-1 values. All outputs are registered, with a fixed latency of 2 cycles from counter state to pins.
REQ-012 pix_rgb SHALL be ignored (rgb forced to 0) whenever active_d1 = 0.
REQ-013 The counter and pipeline arithmetic SHALL be unsigned, 10 bits. H_TOTAL and V_TOTAL SHALL each be at most 1024, checked at elaboration.
REQ-014 On a RUN->IDLE transition, the pipeline SHALL flush to idle values within 2 cycles.

Reset
REQ-015 While rst_n=0:
  - FSM = IDLE, synchroniser = 0, counters = 0
  - pix_req = 0, sof = 0
  - vga_hs = 1, vga_vs = 1, vga_blank_n = 0, rgb = 0, vga_sync_n = 0
REQ-016 After rst_n deasserts, RUN SHALL NOT be entered until lock_s = 1, which takes at least 2 edges.

Structure
REQ-017 A shared package vga_timing_pkg SHALL hold the 640x480@60 default constants, H_TOTAL/V_TOTAL derivations, the FSM state enum and the rgb24 typedef.
REQ-018 One sub-module, vga_timing_counter, SHALL hold the h/v counters, wrap logic and FSM.
REQ-019 The top SHALL contain the synchroniser, the decode logic and the 2-stage output pipeline.

Verification
REQ-020 Reset with pll_locked=1 -> outputs at idle values while rst_n=0. First sof occurs 3 edges after deassertion (2 sync edges + 1). vga_blank_n first rises 2 cycles after sof.
REQ-021 Full frame -> exactly 800 clk per line and 420000 per frame; sof period is 420000 cycles. Per line, vga_hs is low for 96 cycles, starting 656+2 cycles after line start.
REQ-022 Vertical check -> vga_vs is low for 1600 cycles (lines 490-491). vga_blank_n is high for 640 cycles on each of lines 0..479 and low on lines 480..524.
REQ-023 pix_rgb = {pix_x[7:0], pix_y[7:0], 8'hA5} fed 1 cycle after pix_req -> at pixel (5,3), vga_r = 5, vga_g = 3, vga_b = 0xA5, appearing 2 cycles after that pix_req. rgb = 0 outside the active region.
REQ-024 pll_locked dropped at h=300, v=200 -> pix_req = 0 within 3 edges and outputs return to idle values within 2 more. On relock, the frame restarts at h=0, v=0 with a sof pulse.
REQ-025 rst_n asserted mid-line -> all outputs reach reset values immediately (asynchronously), without waiting for a clk edge.
